// File: rtl/int_float_sched_if.sv
// int_float_sched_if: requester and converter signals shared by the scheduler and its environment
//
// Purpose : groups the per-channel request bus and the converter handshake
//           of int_float_sched into one bundle.
// Signals :
//   req          CH_NUM     per-channel request level, held until own ack
//   data_in      16*CH_NUM  channel n operand at [16n+15:16n]
//   conv_start   1          converter start pulse
//   conv_data    16         converter operand, stable from start until response
//   conv_result  32         converter float result
//   conv_done    1          converter completion pulse
//   ack          CH_NUM     one-hot completion pulse to the granted channel
//   result_float 32         IEEE-754 single result, valid with ack, held afterwards
//   result_ch    CH_W       channel index of the current ack
//   err_tmo      1          pulse with ack when the conversion timed out
//   busy         1          scheduler is not idle
// Modports: slave = scheduler side, master = requesters + converter side.
interface int_float_sched_if #(
    parameter int CH_NUM = 8,
    parameter int CH_W   = 3
);
    logic [CH_NUM-1:0]    req;
    logic [16*CH_NUM-1:0] data_in;
    logic                 conv_start;
    logic [15:0]          conv_data;
    logic [31:0]          conv_result;
    logic                 conv_done;
    logic [CH_NUM-1:0]    ack;
    logic [31:0]          result_float;
    logic [CH_W-1:0]      result_ch;
    logic                 err_tmo;
    logic                 busy;

    modport slave (
        input  req, data_in, conv_result, conv_done,
        output conv_start, conv_data, ack, result_float, result_ch, err_tmo, busy
    );

    modport master (
        output req, data_in, conv_result, conv_done,
        input  conv_start, conv_data, ack, result_float, result_ch, err_tmo, busy
    );
endinterface

// File: rtl/int_float_sched.sv
// int_float_sched: round-robin scheduler sharing one 16-bit int->float converter among CH_NUM channels
//
// Purpose : grants one requesting channel at a time, hands its operand to the
//           single converter, waits for done or timeout and returns the result
//           with a one-cycle ack to the granted channel.
// Ports   :
//   clk_sys    in  system clock
//   rst_sys_n  in  asynchronous active-low reset
//   sif        int_float_sched_if.slave (request bus + converter handshake)
// Option  : INT_FLOAT_SCHED_ZERO_BYPASS_EN - a zero operand is answered with
//           +0.0 without starting the converter (ack two cycles after grant).
module int_float_sched #(
    parameter int CH_NUM  = 8,
    parameter int CH_W    = 3,
    parameter int TMO_CYC = 32
) (
    input  logic                    clk_sys,
    input  logic                    rst_sys_n,
    int_float_sched_if.slave        sif
);
    localparam int CNT_W = $clog2(TMO_CYC) + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_idx;
    logic [15:0]       r_conv_data;
    logic [31:0]       r_result;
    logic [CH_W-1:0]   r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pend;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_tmo;
    logic              w_skip;

`ifdef INT_FLOAT_SCHED_ZERO_BYPASS_EN
    assign w_skip = r_conv_data == 16'h0000;
`else
    assign w_skip = 1'b0;
`endif

    assign w_tmo     = r_cnt == CNT_W'(TMO_CYC - 1);
    assign w_gnt_vld = |sif.req;

    // Scan downwards from ptr+CH_NUM-1 to ptr so the last hit is the first set
    // bit at or after ptr in wrap-around order.
    always_comb begin
        int c;
        w_gnt_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            c = int'(r_ptr) + i;
            c = (c >= CH_NUM) ? c - CH_NUM : c;
            if (sif.req[c]) w_gnt_idx = CH_W'(c);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n)
        if (!rst_sys_n) r_state <= S_IDLE;
        else r_state <= w_nxt;

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  w_nxt = w_gnt_vld ? S_START : S_IDLE;
            S_START: w_nxt = w_skip ? S_RESP : S_WAIT;
            S_WAIT:  w_nxt = (sif.conv_done || w_tmo) ? S_RESP : S_WAIT;
            S_RESP:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
    end

    // Result and channel are loaded on the edge into RESP, so they change
    // exactly when ack rises and hold until the next response.
    always_ff @(posedge clk_sys or negedge rst_sys_n)
        if (!rst_sys_n) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_conv_data <= '0;
            r_result    <= '0;
            r_ch        <= '0;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_gnt_vld) begin
                r_idx       <= w_gnt_idx;
                r_conv_data <= sif.data_in[16*w_gnt_idx +: 16];
                r_ptr       <= (w_gnt_idx == CH_W'(CH_NUM - 1)) ? '0 : w_gnt_idx + CH_W'(1);
            end
            if (r_state == S_START) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
                if (w_skip) begin
                    r_result <= '0;
                    r_ch     <= r_idx;
                end
            end
            if (r_state == S_WAIT) begin
                if (sif.conv_done) begin
                    r_result <= sif.conv_result;
                    r_pend   <= 1'b0;
                    r_ch     <= r_idx;
                end else if (w_tmo) begin
                    r_result <= '0;
                    r_pend   <= 1'b1;
                    r_ch     <= r_idx;
                end else r_cnt <= r_cnt + CNT_W'(1);
            end
        end

    assign sif.conv_start   = r_state == S_START && !w_skip;
    assign sif.conv_data    = r_conv_data;
    assign sif.ack          = (r_state == S_RESP) ? {{(CH_NUM-1){1'b0}}, 1'b1} << r_idx : '0;
    assign sif.result_float = r_result;
    assign sif.result_ch    = r_ch;
    assign sif.err_tmo      = r_state == S_RESP && r_pend;
    assign sif.busy         = r_state != S_IDLE;
endmodule
